serial_word_bridge: RTL and testbench

Bit-serial to parallel bridge between the pad ring's single-bit pins and the 16-bit CPU core. It deserializes framed 16-bit words arriving on the serial input pad into a handshaked parallel word for the core. It serializes parallel words from the core onto the serial output pad with the same framing. It contains one receive holding register and one transmit shifter, and sits directly between the input/output pads and the core.

---
 rtl/serial_word_bridge.sv | 132 +++++++++++++
 tb/tb_serial_word_bridge.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_bridge.sv
// serial_word_bridge: framed bit-serial <-> 16-bit handshaked word bridge.
// Start 0, WIDTH data bits MSB first, stop 1; one bit per clock.
module serial_word_bridge #(
  parameter int WIDTH = 16
) (
  input  logic             C,
  input  logic             RN,
  input  logic             SI,
  output logic             SO,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  rx_state_t        rx_state;
  logic [CW-1:0]    rx_cnt;
  logic [WIDTH-1:0] rx_sh;

  tx_state_t        tx_state;
  logic [CW-1:0]    tx_cnt;
  logic [WIDTH-1:0] tx_sh;
  logic             tx_hs;

  assign tx_ready = (tx_state == TX_IDLE) || (tx_state == TX_STOP);
  assign tx_hs    = tx_valid && tx_ready;

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_sh     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          if (!SI) begin
            rx_state <= RX_DATA;
            rx_cnt   <= '0;
          end
        end
        RX_DATA: begin
          rx_sh  <= {rx_sh[WIDTH-2:0], SI};
          rx_cnt <= rx_cnt + CW'(1);
          if (rx_cnt == CW'(WIDTH - 1))
            rx_state <= RX_STOP;
        end
        RX_STOP: begin
          rx_state <= RX_IDLE;
          if (!SI) begin
            frame_err <= 1'b1;
          end else if (!rx_valid || rx_ready) begin
            // a same-edge handshake frees the holding register
            rx_data  <= rx_sh;
            rx_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_sh    <= '0;
      SO       <= 1'b1;
    end else begin
      unique case (tx_state)
        TX_IDLE: begin
          SO <= 1'b1;
          if (tx_hs) begin
            tx_sh    <= tx_data;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          SO       <= 1'b0;
          tx_cnt   <= '0;
          tx_state <= TX_DATA;
        end
        TX_DATA: begin
          SO     <= tx_sh[WIDTH-1];
          tx_sh  <= {tx_sh[WIDTH-2:0], 1'b0};
          tx_cnt <= tx_cnt + CW'(1);
          if (tx_cnt == CW'(WIDTH - 1))
            tx_state <= TX_STOP;
        end
        TX_STOP: begin
          SO <= 1'b1;
          if (tx_hs) begin
            tx_sh    <= tx_data;
            tx_state <= TX_START;
          end else begin
            tx_state <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_bridge.sv
// tb_serial_word_bridge: directed frames, queue scoreboard,
// negedge monitor decoding rx handshakes, error pulses and SO frames.
module tb_serial_word_bridge;

  logic        C = 1'b0;
  logic        RN = 1'b0;
  logic        SI = 1'b1;
  logic        SO;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        frame_err;
  logic        overrun;

  serial_word_bridge #(.WIDTH(16)) dut (
    .C(C), .RN(RN), .SI(SI), .SO(SO),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 C = ~C;

  int checks = 0;
  int errors = 0;

  logic [15:0] rx_q[$];
  logic [15:0] tx_q[$];
  int          ev_q[$];

  bit          tx_busy = 0;
  int          tx_n = 0;
  logic [15:0] tx_w = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic ev_chk(input int code);
    checks++;
    if (ev_q.size() == 0) begin
      errors++;
      $display("FAIL ev_unexpected got=%0d want=none t=%0t", code, $time);
    end else if (ev_q[0] != code) begin
      errors++;
      $display("FAIL ev_kind got=%0d want=%0d t=%0t", code, ev_q[0], $time);
      void'(ev_q.pop_front());
    end else begin
      void'(ev_q.pop_front());
    end
  endtask

  // monitor: 1 = frame_err, 2 = overrun
  always @(negedge C) begin
    if (!RN) begin
      tx_busy = 0;
      tx_n = 0;
    end else begin
      if (rx_valid && rx_ready) begin
        if (rx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected got=%h want=none", rx_data);
        end else begin
          chk("rx_word", 32'(rx_data), 32'(rx_q.pop_front()));
        end
      end
      if (frame_err) ev_chk(1);
      if (overrun) ev_chk(2);
      if (!tx_busy) begin
        if (SO == 1'b0) begin
          tx_busy = 1;
          tx_n = 0;
        end
      end else if (tx_n < 16) begin
        tx_w = {tx_w[14:0], SO};
        tx_n++;
      end else begin
        tx_busy = 0;
        chk("tx_stop", 32'(SO), 32'd1);
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected got=%h want=none", tx_w);
        end else begin
          chk("tx_word", 32'(tx_w), 32'(tx_q.pop_front()));
        end
      end
    end
  end

  task automatic send_frame(input logic [15:0] w, input logic stop_b,
                            input logic rdy_stop);
    logic [17:0] f;
    f = {1'b0, w, stop_b};
    for (int i = 17; i >= 0; i--) begin
      SI = f[i];
      if (i == 0) rx_ready = rdy_stop;
      @(posedge C); #1;
    end
    rx_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    rx_ready = 1'b1;
    @(posedge C); #1;
    rx_ready = 1'b0;
    chk(name, 32'(rx_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] rfr;
    repeat (2) @(posedge C);
    #1;
    chk("rst_so", 32'(SO), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_flags", {30'd0, frame_err, overrun}, 32'd0);
    RN = 1'b1;
    repeat (2) @(posedge C);
    #1;

    // single frame held until accepted
    rx_q.push_back(16'hA5C3);
    send_frame(16'hA5C3, 1'b1, 1'b0);
    SI = 1'b1;
    chk("a5_valid", 32'(rx_valid), 32'd1);
    chk("a5_data", 32'(rx_data), 32'hA5C3);
    repeat (3) begin
      @(posedge C); #1;
      chk("a5_hold", 32'(rx_valid), 32'd1);
    end
    drain("a5_clear");

    // back-to-back, holding register full
    rx_q.push_back(16'h1234);
    ev_q.push_back(2);
    send_frame(16'h1234, 1'b1, 1'b0);
    chk("b2b_valid", 32'(rx_valid), 32'd1);
    chk("b2b_data1", 32'(rx_data), 32'h1234);
    send_frame(16'hFFFF, 1'b1, 1'b0);
    SI = 1'b1;
    chk("ovr_pulse", 32'(overrun), 32'd1);
    chk("ovr_data", 32'(rx_data), 32'h1234);
    @(posedge C); #1;
    chk("ovr_one", 32'(overrun), 32'd0);
    drain("ovr_clear");

    // back-to-back, core accepts on the second stop-bit cycle
    rx_q.push_back(16'h1234);
    rx_q.push_back(16'hFFFF);
    send_frame(16'h1234, 1'b1, 1'b0);
    send_frame(16'hFFFF, 1'b1, 1'b1);
    SI = 1'b1;
    chk("rdy_valid", 32'(rx_valid), 32'd1);
    chk("rdy_data", 32'(rx_data), 32'hFFFF);
    chk("rdy_no_ovr", 32'(overrun), 32'd0);
    drain("rdy_clear");

    // bad stop bit, then a good frame
    ev_q.push_back(1);
    send_frame(16'h00FF, 1'b0, 1'b0);
    SI = 1'b1;
    chk("ferr_pulse", 32'(frame_err), 32'd1);
    chk("ferr_novalid", 32'(rx_valid), 32'd0);
    @(posedge C); #1;
    chk("ferr_one", 32'(frame_err), 32'd0);
    rx_q.push_back(16'h8001);
    send_frame(16'h8001, 1'b1, 1'b0);
    SI = 1'b1;
    chk("r8001_data", 32'(rx_data), 32'h8001);
    drain("r8001_clear");

    // two back-to-back tx words
    tx_q.push_back(16'hC0DE);
    tx_q.push_back(16'hC0DE);
    tx_data = 16'hC0DE;
    tx_valid = 1'b1;
    chk("tx_idle_ready", 32'(tx_ready), 32'd1);
    for (int k = 0; k <= 37; k++) begin
      @(posedge C); #1;
      if (k == 18) tx_valid = 1'b0;
      if (k == 20) tx_data = 16'hFFFF;
      chk("tx_ready_seq", 32'(tx_ready), 32'((k == 17) || (k >= 35)));
      if (k == 1 || k == 19) chk("tx_start_bit", 32'(SO), 32'd0);
      if (k == 18 || k == 36) chk("tx_stop_bit", 32'(SO), 32'd1);
    end

    // reset mid-frame in both directions
    tx_data = 16'h5A5A;
    tx_valid = 1'b1;
    rfr = {1'b0, 16'h3C3C, 1'b1};
    for (int i = 17; i >= 8; i--) begin
      SI = rfr[i];
      @(posedge C); #1;
      tx_valid = 1'b0;
    end
    chk("pre_rst_so", 32'(SO), 32'd0);
    RN = 1'b0;
    SI = 1'b1;
    #1;
    chk("rst_async_so", 32'(SO), 32'd1);
    chk("rst_async_rdy", 32'(tx_ready), 32'd1);
    repeat (2) @(posedge C);
    #1;
    RN = 1'b1;
    repeat (20) @(posedge C);
    #1;
    chk("rst_no_valid", 32'(rx_valid), 32'd0);

    rx_q.push_back(16'h3C3C);
    tx_q.push_back(16'h5A5A);
    tx_valid = 1'b1;
    @(posedge C); #1;
    tx_valid = 1'b0;
    send_frame(16'h3C3C, 1'b1, 1'b0);
    SI = 1'b1;
    chk("post_rst_data", 32'(rx_data), 32'h3C3C);
    drain("post_rst_clear");
    repeat (6) @(posedge C);
    #1;

    chk("rx_q_empty", 32'(rx_q.size()), 32'd0);
    chk("tx_q_empty", 32'(tx_q.size()), 32'd0);
    chk("ev_q_empty", 32'(ev_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
